// File: rtl/fx3_pkg.sv
// Shared types and constants for the FX3 Slave FIFO bus scheduler.
package fx3_pkg;

    localparam int unsigned BURST_DEFAULT = 1024;

    localparam logic [1:0] EP3_OUT = 2'b11;
    localparam logic [1:0] EP0_IN  = 2'b00;
    localparam logic [1:0] EP1_IN  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RD,
        ST_WR,
        ST_FLAG
    } state_t;

    function automatic logic [1:0] ep_addr(input logic [2:0] onehot);
        logic [1:0] addr;
        addr = EP3_OUT;
        if (onehot[1]) begin
            addr = EP0_IN;
        end else if (onehot[2]) begin
            addr = EP1_IN;
        end
        return addr;
    endfunction

    // Pointer value that puts the channel after the granted one first.
    function automatic logic [1:0] rr_next(input logic [2:0] onehot);
        logic [1:0] nxt;
        nxt = 2'd0;
        if (onehot[0]) begin
            nxt = 2'd1;
        end else if (onehot[1]) begin
            nxt = 2'd2;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fx3_bus_scheduler_if.sv
// Slave FIFO strobes, FX3 flags and per-channel handshakes of the bus scheduler.
interface fx3_bus_scheduler_if;

    logic       flaga;
    logic       flagb;
    logic       flagc;
    logic [2:0] req;
    logic       en;

    logic       slcs;
    logic       slrd;
    logic       sloe;
    logic       slwr;
    logic       pktend;
    logic [1:0] faddr;
    logic       fdata_oe;
    logic [2:0] gnt;
    logic       rd_valid;
    logic       wr_take;
    logic       burst_done;

    modport master (
        input  flaga, flagb, flagc, req, en,
        output slcs, slrd, sloe, slwr, pktend, faddr, fdata_oe,
        output gnt, rd_valid, wr_take, burst_done
    );

    modport slave (
        output flaga, flagb, flagc, req, en,
        input  slcs, slrd, sloe, slwr, pktend, faddr, fdata_oe,
        input  gnt, rd_valid, wr_take, burst_done
    );

endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin pick; the pointer names the channel with top priority.
module rr_arbiter3
    import fx3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] eligible,
    input  logic       update,
    output logic [2:0] pick
);

    logic [1:0] ptr;

    always_comb begin
        pick = 3'b000;
        case (ptr)
            2'd1: begin
                if (eligible[1])      pick = 3'b010;
                else if (eligible[2]) pick = 3'b100;
                else if (eligible[0]) pick = 3'b001;
            end
            2'd2: begin
                if (eligible[2])      pick = 3'b100;
                else if (eligible[0]) pick = 3'b001;
                else if (eligible[1]) pick = 3'b010;
            end
            default: begin
                if (eligible[0])      pick = 3'b001;
                else if (eligible[1]) pick = 3'b010;
                else if (eligible[2]) pick = 3'b100;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (update && (pick != 3'b000)) begin
            ptr <= rr_next(pick);
        end
    end

endmodule

// File: rtl/fx3_bus_scheduler.sv
// Burst sequencer for the shared FX3 Slave FIFO bus: grants whole bursts
// round-robin and generates the bus strobes and per-word channel handshakes.
//
// state | meaning
// IDLE  | wait for an eligible channel, latch grant and endpoint address
// SETUP | one cycle of address setup before the first strobe
// RD    | slrd low for BURST cycles, then drain the read-latency pipe
// WR    | wr_take for BURST cycles, slwr trails it by one cycle
// FLAG  | FLAG_WAIT cycles for FX3 flags to settle, burst_done on the last
module fx3_bus_scheduler
    import fx3_pkg::*;
#(
    parameter int unsigned BURST     = BURST_DEFAULT,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned FLAG_WAIT = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    fx3_bus_scheduler_if.master bus
);

    localparam logic [15:0]       LAST_WORD = 16'(BURST - 1);
    localparam logic [2:0]        LAST_WAIT = 3'(FLAG_WAIT - 1);
    localparam logic [RD_LAT-1:0] PIPE_LAST = RD_LAT'(1) << (RD_LAT - 1);

    state_t            state, state_d;
    logic [2:0]        flag_r;
    logic [2:0]        eligible;
    logic [2:0]        pick;
    logic              grant_now;
    logic [15:0]       cnt, cnt_d;
    logic [2:0]        wcnt, wcnt_d;
    logic [2:0]        gnt, gnt_d;
    logic [1:0]        faddr, faddr_d;
    logic              oe, oe_d;
    logic              slrd, slrd_d;
    logic              sloe, sloe_d;
    logic              wr_take, wr_take_d;
    logic              slwr;
    logic              done_pulse;
    logic [RD_LAT-1:0] rd_pipe;

    // Flag bits reordered to channel index: ch0 = flagb, ch1 = flaga, ch2 = flagc.
    assign eligible = bus.req & flag_r & {3{bus.en}};

    rr_arbiter3 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .update   (grant_now),
        .pick     (pick)
    );

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        wcnt_d     = wcnt;
        gnt_d      = gnt;
        faddr_d    = faddr;
        oe_d       = oe;
        slrd_d     = slrd;
        sloe_d     = sloe;
        wr_take_d  = wr_take;
        grant_now  = 1'b0;
        done_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (eligible != 3'b000) begin
                    grant_now = 1'b1;
                    gnt_d     = pick;
                    faddr_d   = ep_addr(pick);
                    oe_d      = !pick[0];
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d = 16'd0;
                if (gnt[0]) begin
                    slrd_d  = 1'b0;
                    sloe_d  = 1'b0;
                    state_d = ST_RD;
                end else begin
                    wr_take_d = 1'b1;
                    state_d   = ST_WR;
                end
            end
            ST_RD: begin
                if (!slrd) begin
                    cnt_d = cnt + 16'd1;
                    if (cnt == LAST_WORD) begin
                        slrd_d = 1'b1;
                    end
                end else if (rd_pipe == PIPE_LAST) begin
                    // Only the final word is left in the pipe: it is on fdata now.
                    sloe_d  = 1'b1;
                    wcnt_d  = 3'd0;
                    state_d = ST_FLAG;
                end
            end
            ST_WR: begin
                if (wr_take) begin
                    cnt_d = cnt + 16'd1;
                    if (cnt == LAST_WORD) begin
                        wr_take_d = 1'b0;
                    end
                end else if (!slwr) begin
                    oe_d    = 1'b0;
                    wcnt_d  = 3'd0;
                    state_d = ST_FLAG;
                end
            end
            ST_FLAG: begin
                if (wcnt == LAST_WAIT) begin
                    done_pulse = 1'b1;
                    gnt_d      = 3'b000;
                    state_d    = ST_IDLE;
                end else begin
                    wcnt_d = wcnt + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            flag_r  <= 3'b000;
            cnt     <= 16'd0;
            wcnt    <= 3'd0;
            gnt     <= 3'b000;
            faddr   <= EP3_OUT;
            oe      <= 1'b0;
            slrd    <= 1'b1;
            sloe    <= 1'b1;
            wr_take <= 1'b0;
            slwr    <= 1'b1;
            rd_pipe <= '0;
        end else begin
            state   <= state_d;
            flag_r  <= {bus.flagc, bus.flaga, bus.flagb};
            cnt     <= cnt_d;
            wcnt    <= wcnt_d;
            gnt     <= gnt_d;
            faddr   <= faddr_d;
            oe      <= oe_d;
            slrd    <= slrd_d;
            sloe    <= sloe_d;
            wr_take <= wr_take_d;
            slwr    <= !wr_take;
            rd_pipe[0] <= !slrd;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign bus.slcs       = 1'b0;
    assign bus.pktend     = 1'b1;
    assign bus.slrd       = slrd;
    assign bus.sloe       = sloe;
    assign bus.slwr       = slwr;
    assign bus.faddr      = faddr;
    assign bus.fdata_oe   = oe;
    assign bus.gnt        = gnt;
    assign bus.rd_valid   = rd_pipe[RD_LAT-1];
    assign bus.wr_take    = wr_take;
    assign bus.burst_done = done_pulse;

endmodule

// File: tb/tb_fx3_bus_scheduler.sv
// Randomized scoreboard bench for fx3_bus_scheduler with a round-robin grant model.
module tb_fx3_bus_scheduler;

    localparam int BURST     = 8;
    localparam int RD_LAT    = 2;
    localparam int FLAG_WAIT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fx3_bus_scheduler_if bus ();

    fx3_bus_scheduler #(
        .BURST     (BURST),
        .RD_LAT    (RD_LAT),
        .FLAG_WAIT (FLAG_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int ch;
        int lat;
        int commit_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   rr_ptr  = 0;
    bit   at_done = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    function automatic int addr_of(input int ch);
        return (ch == 0) ? 3 : ((ch == 1) ? 0 : 1);
    endfunction

    // Channel the round-robin rule selects, or -1 when nothing is eligible.
    function automatic int model_pick(input logic [2:0] r, input logic [2:0] f, input logic e);
        int c;
        if (!e) return -1;
        for (int k = 0; k < 3; k++) begin
            c = (rr_ptr + k) % 3;
            if (r[c] && f[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive(input logic [2:0] r, input logic [2:0] f, input logic e);
        bus.req   = r;
        bus.flagb = f[0];
        bus.flaga = f[1];
        bus.flagc = f[2];
        bus.en    = e;
    endtask

    // Presents the next request pattern; flags settle before en so the grant sees a clean pattern.
    task automatic commit(input logic [2:0] r, input logic [2:0] f, input logic e, output bit granted);
        exp_t x;
        int   c;
        if (at_done) begin
            drive(r, f, e);
            x.lat = 3;
        end else begin
            drive(r, f, 1'b0);
            @(negedge clk);
            drive(r, f, e);
            x.lat = 2;
        end
        c = model_pick(r, f, e);
        granted = (c >= 0);
        if (granted) begin
            x.ch         = c;
            x.commit_cyc = cyc;
            exp_q.push_back(x);
            rr_ptr = (c + 1) % 3;
        end
    endtask

    // mode 0: hold inputs, 1: random inputs mid-burst, 2: all flags dropped mid-burst
    task automatic run_burst(input int mode);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BURST + RD_LAT + FLAG_WAIT + 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.burst_done) seen = 1'b1;
            else if (i >= 1 && mode == 1) drive(3'($urandom), 3'($urandom), 1'($urandom));
            else if (i >= 1 && mode == 2) drive(bus.req, 3'b000, bus.en);
        end
        check("burst_done_seen", int'(seen), 1);
        at_done = seen;
    endtask

    task automatic idle_hold(input int n);
        repeat (n) @(negedge clk);
        at_done = 1'b0;
    endtask

    // Monitor: pops the expected burst at grant and checks the whole burst at burst_done.
    exp_t cur;
    bit   active = 1'b0;
    int   grant_cyc, n_oe, hold_bad, const_bad;
    int   n_slrd, f_slrd, l_slrd, n_sloe, f_sloe;
    int   n_rdv, f_rdv, l_rdv, n_take, f_take, l_take, n_slwr, f_slwr, l_slwr;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
        end else if (!active) begin
            if (bus.gnt != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", int'(bus.gnt), 0);
                end else begin
                    cur = exp_q.pop_front();
                    active = 1'b1;
                    grant_cyc = cyc;
                    n_oe = int'(bus.fdata_oe);
                    hold_bad = 0; const_bad = 0;
                    n_slrd = 0; f_slrd = -1; l_slrd = -1; n_sloe = 0; f_sloe = -1;
                    n_rdv = 0; f_rdv = -1; l_rdv = -1; n_take = 0; f_take = -1; l_take = -1;
                    n_slwr = 0; f_slwr = -1; l_slwr = -1;
                    check("gnt", int'(bus.gnt), 1 << cur.ch);
                    check("faddr", int'(bus.faddr), addr_of(cur.ch));
                    check("oe_at_setup", int'(bus.fdata_oe), int'(cur.ch != 0));
                end
            end else begin
                check("idle_quiet", int'({bus.slcs, bus.pktend, bus.slrd, bus.sloe, bus.slwr,
                      bus.rd_valid, bus.wr_take, bus.burst_done, bus.fdata_oe}), 9'b011110000);
            end
        end else begin
            if (bus.gnt != 3'(1 << cur.ch)) hold_bad++;
            if (bus.slcs != 1'b0 || bus.pktend != 1'b1) const_bad++;
            if (bus.fdata_oe) n_oe++;
            if (!bus.slrd) begin n_slrd++; if (f_slrd < 0) f_slrd = cyc; l_slrd = cyc; end
            if (!bus.sloe) begin n_sloe++; if (f_sloe < 0) f_sloe = cyc; end
            if (bus.rd_valid) begin n_rdv++; if (f_rdv < 0) f_rdv = cyc; l_rdv = cyc; end
            if (bus.wr_take) begin n_take++; if (f_take < 0) f_take = cyc; l_take = cyc; end
            if (!bus.slwr) begin n_slwr++; if (f_slwr < 0) f_slwr = cyc; l_slwr = cyc; end
            if (bus.burst_done) begin
                active = 1'b0;
                check("gnt_held", hold_bad, 0);
                check("slcs_pktend", const_bad, 0);
                if (cur.ch == 0) begin
                    check("rd_slrd_cnt", n_slrd, BURST);
                    check("rd_slrd_span", l_slrd - f_slrd + 1, BURST);
                    check("rd_valid_cnt", n_rdv, BURST);
                    check("rd_valid_span", l_rdv - f_rdv + 1, BURST);
                    check("rd_latency", f_rdv - f_slrd, RD_LAT);
                    check("rd_sloe_cnt", n_sloe, BURST + RD_LAT);
                    check("rd_sloe_start", f_sloe - f_slrd, 0);
                    check("rd_no_write", n_take + n_slwr + n_oe, 0);
                    check("start_latency", f_slrd - cur.commit_cyc, cur.lat);
                    check("flag_gap", cyc - l_rdv, FLAG_WAIT);
                end else begin
                    check("wr_take_cnt", n_take, BURST);
                    check("wr_take_span", l_take - f_take + 1, BURST);
                    check("wr_slwr_cnt", n_slwr, BURST);
                    check("wr_slwr_span", l_slwr - f_slwr + 1, BURST);
                    check("wr_slwr_lag", f_slwr - f_take, 1);
                    check("wr_oe_window", n_oe, l_slwr - grant_cyc + 1);
                    check("wr_no_read", n_slrd + n_sloe + n_rdv, 0);
                    check("start_latency", f_take - cur.commit_cyc, cur.lat);
                    check("flag_gap", cyc - l_slwr, FLAG_WAIT);
                end
            end
        end
    end

    initial begin
        bit g;
        bit seen;
        drive(3'b000, 3'b000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_strobes", int'({bus.slcs, bus.slrd, bus.sloe, bus.slwr, bus.pktend}), 5'b01111);
        check("rst_faddr", int'(bus.faddr), 3);
        check("rst_gnt", int'(bus.gnt), 0);
        check("rst_handshake", int'({bus.fdata_oe, bus.rd_valid, bus.wr_take, bus.burst_done}), 0);

        // Everything requested but disabled: bus must stay quiet.
        drive(3'b111, 3'b111, 1'b0);
        idle_hold(8);
        commit(3'b111, 3'b111, 1'b1, g);
        run_burst(0);
        repeat (3) begin
            commit(3'b111, 3'b111, 1'b1, g);
            run_burst(0);
        end

        // ch1 alone, flags dropped mid-burst, then not regranted until its flag returns.
        commit(3'b010, 3'b010, 1'b1, g);
        run_burst(2);
        commit(3'b010, 3'b000, 1'b1, g);
        idle_hold(6);
        commit(3'b010, 3'b010, 1'b1, g);
        run_burst(0);

        repeat (30) begin
            commit(3'($urandom), 3'($urandom), 1'($urandom_range(0, 5) != 0), g);
            if (g) run_burst(1);
            else idle_hold($urandom_range(2, 6));
        end

        // Reset in the middle of a read burst.
        commit(3'b001, 3'b001, 1'b1, g);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (!bus.slrd) seen = 1'b1;
        end
        check("rd_started", int'(seen), 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_strobes", int'({bus.slrd, bus.sloe, bus.slwr}), 3'b111);
        check("async_rst_gnt", int'(bus.gnt), 0);
        rr_ptr = 0;
        exp_q.delete();
        drive(3'b111, 3'b111, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        at_done = 1'b0;
        commit(3'b111, 3'b111, 1'b1, g);
        run_burst(0);

        commit(3'b000, 3'b000, 1'b0, g);
        idle_hold(5);
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
